ascii_key_injector: RTL and testbench

//  Converts an ASCII text file streamed from the HPS ioctl download port into

---
 rtl/ascii_key_injector_pkg.sv | 39 +++
 rtl/ascii_key_injector_if.sv | 24 ++
 rtl/ascii_key_injector_text_fifo.sv | 83 ++++++++
 rtl/ascii_key_injector.sv | 125 ++++++++++++
 tb/tb_ascii_key_injector.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_key_injector_pkg.sv
// Shared constants, FSM encoding and the byte filter for the ASCII keystroke injector.
// Imported by the FIFO and the top level.
package ascii_key_injector_pkg;

    localparam logic [6:0] AsciiCr      = 7'h0D;
    localparam logic [7:0] AsciiCrByte  = 8'h0D;
    localparam logic [7:0] AsciiLf      = 8'h0A;
    localparam logic [7:0] AsciiLowerA  = 8'h61;
    localparam logic [7:0] AsciiLowerZ  = 8'h7A;
    localparam logic [7:0] AsciiPrintLo = 8'h20;
    localparam logic [7:0] AsciiPrintHi = 8'h7E;
    localparam logic [7:0] CaseShift    = 8'h20;

    typedef enum logic [1:0] {StIdle, StFetch, StPresent, StGap} state_e;

    typedef struct packed {
        logic       keep;
        logic [6:0] code;
    } filt_t;

    // Apple-I only has upper case; LF becomes CR unless it completes a CRLF pair.
    function automatic filt_t filter_byte(input logic [7:0] b, input logic prev_cr);
        filt_t f;
        f.keep = 1'b1;
        f.code = b[6:0];
        if (b >= AsciiLowerA && b <= AsciiLowerZ) begin
            f.code = 7'(b - CaseShift);
        end else if (b == AsciiLf) begin
            f.keep = ~prev_cr;
            f.code = AsciiCr;
        end else if (b == AsciiCrByte) begin
            f.code = AsciiCr;
        end else if (b < AsciiPrintLo || b > AsciiPrintHi) begin
            f.keep = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/ascii_key_injector_if.sv
// Download-port and keyboard-side signals of the keystroke injector.
// slave is the injector's view, master is the surrounding system's view.
interface ascii_key_injector_if;

    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;
    logic [6:0] key_data;
    logic       key_valid;
    logic       key_ack;
    logic       busy;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_dout, key_ack,
        input  ioctl_wait, key_data, key_valid, busy
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_dout, key_ack,
        output ioctl_wait, key_data, key_valid, busy
    );

endinterface

// File: rtl/ascii_key_injector_text_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and an almost-full flag.
// Flush empties it in one cycle; a write in the flush cycle lands in the emptied FIFO.
module ascii_key_injector_text_fifo #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic [AW:0]   count_o,
    output logic          almost_full_o
);

    localparam int unsigned Depth     = 1 << AW;
    localparam logic [AW:0] FullCount = (AW + 1)'(Depth);
    localparam logic [AW:0] WaitCount = (AW + 1)'(Depth - 2);

    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          almost_full_q, almost_full_d;
    logic          wr_fire, rd_fire;
    logic [AW-1:0] wr_addr;

    always_comb begin
        wr_fire   = wr_en_i & (flush_i | (count_q != FullCount));
        rd_fire   = rd_en_i & ~flush_i & (count_q != '0);
        wr_addr   = flush_i ? '0 : wr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = wr_fire ? AW'(1) : '0;
            count_d  = wr_fire ? (AW + 1)'(1) : '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                rd_data_d = mem_q[rd_ptr_q];
            end
            count_d = count_q + (AW + 1)'(wr_fire) - (AW + 1)'(rd_fire);
        end
        // Two entries of slack cover the write already in flight when the flag rises.
        almost_full_d = count_d >= WaitCount;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_data_q     <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_data_q     <= rd_data_d;
            almost_full_q <= almost_full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire && !rst_i) begin
            mem_q[wr_addr] <= wr_data_i;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign count_o       = count_q;
    assign almost_full_o = almost_full_q;

endmodule

// File: rtl/ascii_key_injector.sv
// Turns a downloaded text file into paced Apple-I keystrokes: filter, buffer, then
// present one key at a time and wait a gap (longer after CR) once the CPU takes it.
module ascii_key_injector
    import ascii_key_injector_pkg::*;
#(
    parameter int unsigned FIFO_AW    = 10,
    parameter int unsigned GAP_CYCLES = 2500,
    parameter int unsigned CR_CYCLES  = 250000
) (
    input logic                 clk_sys,
    input logic                 reset,
    ascii_key_injector_if.slave io
);

    localparam int unsigned GapMax  = (CR_CYCLES > GAP_CYCLES) ? CR_CYCLES : GAP_CYCLES;
    localparam int unsigned GapW    = ($clog2(GapMax + 1) > 18) ? $clog2(GapMax + 1) : 18;
    localparam logic [GapW-1:0] CrLoad  = GapW'(CR_CYCLES);
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);

    state_e            state_q, state_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [6:0]        key_data_q, key_data_d;
    logic              key_valid_q, key_valid_d;
    logic              dl_q;
    logic              prev_cr_q, prev_cr_d;
    logic              dl_rise;
    logic              fifo_rd;
    logic              fifo_empty;
    logic              fifo_wait;
    logic [6:0]        fifo_rd_data;
    logic [FIFO_AW:0]  fifo_count;
    filt_t             filt;

    assign dl_rise    = io.ioctl_download & ~dl_q;
    assign filt       = filter_byte(io.ioctl_dout, prev_cr_q & ~dl_rise);
    assign fifo_empty = fifo_count == '0;
    assign fifo_rd    = (state_q == StIdle) & ~fifo_empty & ~dl_rise;

    // Tracks the raw byte so a dropped LF still breaks a CRLF pair.
    always_comb begin
        prev_cr_d = prev_cr_q & ~dl_rise;
        if (io.ioctl_wr) begin
            prev_cr_d = io.ioctl_dout == AsciiCrByte;
        end
    end

    ascii_key_injector_text_fifo #(
        .AW (FIFO_AW),
        .DW (7)
    ) u_fifo (
        .clk_i         (clk_sys),
        .rst_i         (reset),
        .flush_i       (dl_rise),
        .wr_en_i       (io.ioctl_wr & filt.keep),
        .wr_data_i     (filt.code),
        .rd_en_i       (fifo_rd),
        .rd_data_o     (fifo_rd_data),
        .count_o       (fifo_count),
        .almost_full_o (fifo_wait)
    );

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        key_data_d  = key_data_q;
        key_valid_d = key_valid_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                key_data_d  = fifo_rd_data;
                key_valid_d = 1'b1;
                state_d     = StPresent;
            end
            StPresent: begin
                if (io.key_ack) begin
                    key_valid_d = 1'b0;
                    gap_d       = (key_data_q == AsciiCr) ? CrLoad : GapLoad;
                    state_d     = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q - GapW'(1);
                if (gap_q <= GapW'(1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new download abandons whatever was being typed.
        if (dl_rise) begin
            state_d     = StIdle;
            key_valid_d = 1'b0;
            gap_d       = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            gap_q       <= '0;
            key_data_q  <= '0;
            key_valid_q <= 1'b0;
            dl_q        <= 1'b0;
            prev_cr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            dl_q        <= io.ioctl_download;
            prev_cr_q   <= prev_cr_d;
        end
    end

    assign io.ioctl_wait = fifo_wait;
    assign io.key_data  = key_data_q;
    assign io.key_valid = key_valid_q;
    assign io.busy      = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_ascii_key_injector.sv
// Directed bench for ascii_key_injector: filter table, latency/gap timing, FIFO
// backpressure and overflow, download restart, reset and stray acks.
module tb_ascii_key_injector;

    localparam int unsigned FifoAw = 10;
    localparam int unsigned Gap    = 8;
    localparam int unsigned Cr     = 40;
    localparam int          Limit  = 200;
    localparam int          NVec   = 21;

    typedef struct packed {
        logic [7:0] din;
        logic       drop;
        logic [6:0] key;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    ascii_key_injector_if io ();

    ascii_key_injector #(
        .FIFO_AW    (FifoAw),
        .GAP_CYCLES (Gap),
        .CR_CYCLES  (Cr)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io      (io)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        io.ioctl_wr   = 1'b1;
        io.ioctl_dout = b;
        tick();
        io.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int t);
        t = 0;
        while (io.key_valid !== 1'b1 && t < Limit) begin
            tick();
            t++;
        end
        n_cmp++;
        if (io.key_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: key_valid never rose within %0d cycles", name, Limit);
        end
    endtask

    task automatic ack();
        io.key_ack = 1'b1;
        tick();
        io.key_ack = 1'b0;
    endtask

    // Starts one cycle after the ack edge; returns cycles until busy drops.
    task automatic wait_idle(output int t);
        t = 1;
        while (io.busy !== 1'b0 && t < Limit) begin
            tick();
            t++;
        end
    endtask

    vec_t       vecs [NVec];
    logic [6:0] hello [6];
    int         t;
    int         t2;
    int         acc;
    int         seen;
    logic [7:0] e;

    initial begin
        vecs[0]  = '{8'h68, 1'b0, 7'h48};
        vecs[1]  = '{8'h65, 1'b0, 7'h45};
        vecs[2]  = '{8'h6C, 1'b0, 7'h4C};
        vecs[3]  = '{8'h6C, 1'b0, 7'h4C};
        vecs[4]  = '{8'h6F, 1'b0, 7'h4F};
        vecs[5]  = '{8'h0A, 1'b0, 7'h0D};
        vecs[6]  = '{8'h0D, 1'b0, 7'h0D};
        vecs[7]  = '{8'h0A, 1'b1, 7'h00};
        vecs[8]  = '{8'h0A, 1'b0, 7'h0D};
        vecs[9]  = '{8'h09, 1'b1, 7'h00};
        vecs[10] = '{8'h1B, 1'b1, 7'h00};
        vecs[11] = '{8'h80, 1'b1, 7'h00};
        vecs[12] = '{8'h41, 1'b0, 7'h41};
        vecs[13] = '{8'h7E, 1'b0, 7'h7E};
        vecs[14] = '{8'h7F, 1'b1, 7'h00};
        vecs[15] = '{8'h20, 1'b0, 7'h20};
        vecs[16] = '{8'h61, 1'b0, 7'h41};
        vecs[17] = '{8'h7A, 1'b0, 7'h5A};
        vecs[18] = '{8'h7B, 1'b0, 7'h7B};
        vecs[19] = '{8'h60, 1'b0, 7'h60};
        vecs[20] = '{8'h1F, 1'b1, 7'h00};
        hello    = '{7'h48, 7'h45, 7'h4C, 7'h4C, 7'h4F, 7'h0D};

        reset             = 1'b1;
        io.ioctl_download = 1'b0;
        io.ioctl_wr       = 1'b0;
        io.ioctl_dout     = 8'h00;
        io.key_ack        = 1'b0;
        repeat (3) tick();
        check("rst_wait", 32'(io.ioctl_wait), 32'd0);
        check("rst_key_data", 32'(io.key_data), 32'd0);
        check("rst_key_valid", 32'(io.key_valid), 32'd0);
        check("rst_busy", 32'(io.busy), 32'd0);
        reset             = 1'b0;
        io.ioctl_download = 1'b1;
        repeat (2) tick();

        // Filter table, one byte at a time from idle.
        for (int i = 0; i < NVec; i++) begin
            write_byte(vecs[i].din);
            if (vecs[i].drop) begin
                repeat (6) tick();
                check($sformatf("vec%0d_drop_valid", i), 32'(io.key_valid), 32'd0);
                check($sformatf("vec%0d_drop_busy", i), 32'(io.busy), 32'd0);
            end else begin
                tick();
                check($sformatf("vec%0d_lat_t2", i), 32'(io.key_valid), 32'd0);
                tick();
                check($sformatf("vec%0d_lat_t3", i), 32'(io.key_valid), 32'd1);
                check($sformatf("vec%0d_key", i), 32'(io.key_data), 32'(vecs[i].key));
                repeat (10) tick();
                ack();
                check($sformatf("vec%0d_ack_valid", i), 32'(io.key_valid), 32'd0);
                check($sformatf("vec%0d_hold", i), 32'(io.key_data), 32'(vecs[i].key));
                wait_idle(t);
                check($sformatf("vec%0d_gap", i), t,
                      (vecs[i].key == 7'h0D) ? Cr + 1 : Gap + 1);
            end
        end

        // "hello\n" back to back; the CPU reads each key 10 cycles after it appears.
        foreach (hello[k]) write_byte(8'h68 + 8'(k == 1) * 8'hFD + 8'(k == 2 || k == 3) * 8'h04
                                      + 8'(k == 4) * 8'h07 + 8'(k == 5) * 8'hA2);
        for (int k = 0; k < 6; k++) begin
            wait_valid($sformatf("hello%0d_wait", k), t);
            if (k > 0) check($sformatf("hello%0d_gap", k), t, Gap + 2);
            check($sformatf("hello%0d_key", k), 32'(io.key_data), 32'(hello[k]));
            repeat (10) tick();
            ack();
        end
        wait_idle(t);
        check("hello_cr_gap", t, Cr + 1);

        // CR LF LF collapses to two CRs.
        write_byte(8'h0D);
        write_byte(8'h0A);
        write_byte(8'h0A);
        for (int k = 0; k < 2; k++) begin
            wait_valid($sformatf("crlf%0d_wait", k), t);
            check($sformatf("crlf%0d_key", k), 32'(io.key_data), 32'h0D);
            ack();
        end
        wait_idle(t);
        check("crlf_extra", 32'(io.busy), 32'd0);

        // Control and high bytes vanish; only 'A' is typed.
        write_byte(8'h09);
        write_byte(8'h1B);
        write_byte(8'h80);
        write_byte(8'h41);
        wait_valid("ctl_wait", t);
        check("ctl_key", 32'(io.key_data), 32'h41);
        ack();
        wait_idle(t);
        check("ctl_extra", 32'(io.busy), 32'd0);

        // Stream with no acks: backpressure, slack writes, then drops while full.
        acc = 0;
        while (io.ioctl_wait == 1'b0 && acc < 1100) begin
            write_byte(8'h21 + 8'(acc % 62));
            acc++;
        end
        check("wait_after_writes", acc, 1023);
        write_byte(8'h21 + 8'(acc % 62));
        acc++;
        write_byte(8'h21 + 8'(acc % 62));
        acc++;
        check("wait_when_full", 32'(io.ioctl_wait), 32'd1);
        for (int k = 0; k < 3; k++) write_byte(8'h7E);
        for (int j = 0; j < 1025; j++) begin
            wait_valid($sformatf("stream%0d_wait", j), t);
            e = 8'h21 + 8'(j % 62);
            check($sformatf("stream%0d_key", j), 32'(io.key_data), 32'(e));
            ack();
        end
        wait_idle(t);
        check("stream_no_extra", 32'(io.busy), 32'd0);
        check("stream_wait_clear", 32'(io.ioctl_wait), 32'd0);

        // Restart download while a key is presented.
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        write_byte(8'h44);
        check("dl_presenting", 32'(io.key_valid), 32'd1);
        io.ioctl_download = 1'b0;
        tick();
        io.ioctl_download = 1'b1;
        tick();
        check("dl_valid_drop", 32'(io.key_valid), 32'd0);
        check("dl_busy_drop", 32'(io.busy), 32'd0);
        write_byte(8'h58);
        write_byte(8'h59);
        wait_valid("dl_x_wait", t);
        check("dl_x_key", 32'(io.key_data), 32'h58);
        ack();
        wait_valid("dl_y_wait", t);
        check("dl_y_key", 32'(io.key_data), 32'h59);
        ack();
        seen = 0;
        repeat (Gap + 6) begin
            tick();
            if (io.key_valid === 1'b1) seen++;
        end
        check("dl_no_old_keys", seen, 0);
        check("dl_idle", 32'(io.busy), 32'd0);

        // Reset while presenting, then stray acks in idle and gap.
        write_byte(8'h51);
        tick();
        tick();
        check("rst2_presenting", 32'(io.key_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_valid", 32'(io.key_valid), 32'd0);
        check("rst2_busy", 32'(io.busy), 32'd0);
        check("rst2_key_data", 32'(io.key_data), 32'd0);
        check("rst2_wait", 32'(io.ioctl_wait), 32'd0);
        ack();
        check("idle_ack_valid", 32'(io.key_valid), 32'd0);
        check("idle_ack_busy", 32'(io.busy), 32'd0);
        tick();
        write_byte(8'h52);
        write_byte(8'h53);
        wait_valid("gapack_r_wait", t);
        check("gapack_r_key", 32'(io.key_data), 32'h52);
        ack();
        repeat (3) tick();
        ack();
        check("gapack_busy", 32'(io.busy), 32'd1);
        check("gapack_valid", 32'(io.key_valid), 32'd0);
        wait_valid("gapack_s_wait", t2);
        check("gapack_timing", 5 + t2, Gap + 3);
        check("gapack_s_key", 32'(io.key_data), 32'h53);
        ack();
        wait_idle(t);
        check("final_idle", 32'(io.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
